// File: rtl/io_ring_stop_if.sv
// Ring-stop signal bundle: ring input (Q500), ring output (Q503), local memory request (Q501)
// and local memory response (Q502). The stop itself uses the slave view.
interface io_ring_stop_if #(
    parameter int TILE_ID_W = 10,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 2
);
    logic [TILE_ID_W-1:0] TileIdStrapQnnnH;

    logic                 ReqValidQ500H;
    logic [OP_W-1:0]      ReqOpcodeQ500H;
    logic [ADDR_W-1:0]    ReqAddressQ500H;
    logic [DATA_W-1:0]    ReqDataQ500H;

    logic                 RspValidQ503H;
    logic [OP_W-1:0]      RspOpcodeQ503H;
    logic [ADDR_W-1:0]    RspAddressQ503H;
    logic [DATA_W-1:0]    RspDataQ503H;

    logic                 ReqValidQ501H;
    logic [OP_W-1:0]      ReqOpcodeQ501H;
    logic [ADDR_W-1:0]    ReqAddressQ501H;
    logic [DATA_W-1:0]    ReqDataQ501H;

    logic                 RspValidQ502H;
    logic [OP_W-1:0]      RspOpcodeQ502H;
    logic [ADDR_W-1:0]    RspAddressQ502H;
    logic [DATA_W-1:0]    RspDataQ502H;

    modport slave (
        input  TileIdStrapQnnnH,
        input  ReqValidQ500H, ReqOpcodeQ500H, ReqAddressQ500H, ReqDataQ500H,
        output RspValidQ503H, RspOpcodeQ503H, RspAddressQ503H, RspDataQ503H,
        output ReqValidQ501H, ReqOpcodeQ501H, ReqAddressQ501H, ReqDataQ501H,
        input  RspValidQ502H, RspOpcodeQ502H, RspAddressQ502H, RspDataQ502H
    );

    modport master (
        output TileIdStrapQnnnH,
        output ReqValidQ500H, ReqOpcodeQ500H, ReqAddressQ500H, ReqDataQ500H,
        input  RspValidQ503H, RspOpcodeQ503H, RspAddressQ503H, RspDataQ503H,
        input  ReqValidQ501H, ReqOpcodeQ501H, ReqAddressQ501H, ReqDataQ501H,
        output RspValidQ502H, RspOpcodeQ502H, RspAddressQ502H, RspDataQ502H
    );
endinterface

// File: rtl/io_ring_stop.sv
// Ring stop for one tile: local requests go to memory under a credit check, everything else
// passes through in 3 cycles; memory responses are queued and injected into idle slots.
// Optional statistics counters are enabled by defining IO_RING_STATS_EN.
module io_ring_stop #(
    parameter int TILE_ID_W      = 10,
    parameter int TILE_ID_LSB    = 22,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int OP_W           = 2,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic           QClk,
    input  logic           RstQnnnH,
`ifdef IO_RING_STATS_EN
    output logic [15:0]    RetryCntQnnnH,
    output logic [15:0]    InjectStallCntQnnnH,
`endif
    io_ring_stop_if.slave  ring
);
    localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ringPayload_t;

    ringPayload_t reqPayload, rspPayload;
    ringPayload_t memReqReg, slot501Reg, slot502Reg, outReg, fifoHead;
    logic         memReqValidReg, slot501ValidReg, slot502ValidReg, outValidReg;

    ringPayload_t fifoMem [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
    logic [CNT_W-1:0] fifoCntReg, outstCntReg;
    logic [CNT_W:0]   creditSum;

    logic match, credit, accept, passThru;
    logic rspLegal, fifoPush, fifoPop, fifoNotEmpty;

    assign reqPayload = '{op: ring.ReqOpcodeQ500H, addr: ring.ReqAddressQ500H, data: ring.ReqDataQ500H};
    assign rspPayload = '{op: ring.RspOpcodeQ502H, addr: ring.RspAddressQ502H, data: ring.RspDataQ502H};

    // Credit covers both queued responses and responses still owed by memory.
    assign match     = ring.ReqValidQ500H &&
                       (ring.ReqAddressQ500H[TILE_ID_LSB +: TILE_ID_W] == ring.TileIdStrapQnnnH);
    assign creditSum = {1'b0, fifoCntReg} + {1'b0, outstCntReg};
    assign credit    = creditSum < (CNT_W+1)'(RSP_FIFO_DEPTH);
    assign accept    = match && credit;
    assign passThru  = ring.ReqValidQ500H && !accept;

    // Responses with nothing outstanding are dropped rather than allowed to corrupt credits.
    assign rspLegal     = ring.RspValidQ502H && (outstCntReg != '0);
    assign fifoPush     = rspLegal;
    assign fifoNotEmpty = (fifoCntReg != '0);
    assign fifoPop      = fifoNotEmpty && !slot502ValidReg;
    assign fifoHead     = fifoMem[rdPtrReg];

    always_ff @(posedge QClk) begin
        if (fifoPush) begin
            fifoMem[wrPtrReg] <= rspPayload;
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            memReqValidReg  <= 1'b0;
            memReqReg       <= '0;
            slot501ValidReg <= 1'b0;
            slot501Reg      <= '0;
            slot502ValidReg <= 1'b0;
            slot502Reg      <= '0;
            outValidReg     <= 1'b0;
            outReg          <= '0;
        end else begin
            memReqValidReg <= accept;
            if (accept) begin
                memReqReg <= reqPayload;
            end
            slot501ValidReg <= passThru;
            if (passThru) begin
                slot501Reg <= reqPayload;
            end
            slot502ValidReg <= slot501ValidReg;
            if (slot501ValidReg) begin
                slot502Reg <= slot501Reg;
            end
            // Pass-through traffic always wins the Q503 slot over queued responses.
            if (slot502ValidReg) begin
                outValidReg <= 1'b1;
                outReg      <= slot502Reg;
            end else if (fifoNotEmpty) begin
                outValidReg <= 1'b1;
                outReg      <= fifoHead;
            end else begin
                outValidReg <= 1'b0;
            end
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            fifoCntReg  <= '0;
            outstCntReg <= '0;
        end else begin
            if (fifoPush) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (fifoPop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            unique case ({fifoPush, fifoPop})
                2'b10:   fifoCntReg <= fifoCntReg + 1'b1;
                2'b01:   fifoCntReg <= fifoCntReg - 1'b1;
                default: fifoCntReg <= fifoCntReg;
            endcase
            unique case ({accept, rspLegal})
                2'b10:   outstCntReg <= outstCntReg + 1'b1;
                2'b01:   outstCntReg <= outstCntReg - 1'b1;
                default: outstCntReg <= outstCntReg;
            endcase
        end
    end

    assign ring.ReqValidQ501H   = memReqValidReg;
    assign ring.ReqOpcodeQ501H  = memReqReg.op;
    assign ring.ReqAddressQ501H = memReqReg.addr;
    assign ring.ReqDataQ501H    = memReqReg.data;

    assign ring.RspValidQ503H   = outValidReg;
    assign ring.RspOpcodeQ503H  = outReg.op;
    assign ring.RspAddressQ503H = outReg.addr;
    assign ring.RspDataQ503H    = outReg.data;

`ifdef IO_RING_STATS_EN
    logic [1:0]  statEvent;
    logic [15:0] statCntReg [2];

    assign statEvent[0] = match && !credit;
    assign statEvent[1] = fifoNotEmpty && slot502ValidReg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge QClk or posedge RstQnnnH) begin
                if (RstQnnnH) begin
                    statCntReg[gi] <= '0;
                end else if (statEvent[gi] && (statCntReg[gi] != 16'hFFFF)) begin
                    statCntReg[gi] <= statCntReg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign RetryCntQnnnH       = statCntReg[0];
    assign InjectStallCntQnnnH = statCntReg[1];
`endif

    strayRspDropped: assert property (@(posedge QClk) disable iff (RstQnnnH)
        !(ring.RspValidQ502H && (outstCntReg == '0)));

endmodule
